// File: rtl/servo_pkg.sv
// Shared constants, state encoding and clamp helper for the servo PWM pulse decoder.
package servo_pkg;

  localparam int CLK_HZ_DEF     = 100_000_000;
  localparam int MIN_US_DEF     = 1000;
  localparam int MAX_US_DEF     = 2000;
  localparam int GUARD_US_DEF   = 100;
  localparam int TIMEOUT_US_DEF = 25000;
  localparam int POS_W_DEF      = 10;
  localparam int US_DIV         = CLK_HZ_DEF / 1_000_000;
  localparam int CENTER_POS     = (MAX_US_DEF - MIN_US_DEF) / 2;

  localparam int WIDTH_W = 12;
  localparam int SINCE_W = 15;

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    MEASURE
  } dec_state_t;

  function automatic logic [WIDTH_W-1:0] clamp_w(input logic [WIDTH_W-1:0] v,
                                                 input logic [WIDTH_W-1:0] lo,
                                                 input logic [WIDTH_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running 1 us strobe generator; clr restarts the period so a measurement
// begins on a tick boundary.
module us_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_pwm_decoder.sv
// RC servo pulse-width decoder: measures high time in microseconds, maps it to a
// position code, and flags out-of-window pulses and loss of the pulse stream.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int MIN_US     = MIN_US_DEF,
  parameter int MAX_US     = MAX_US_DEF,
  parameter int GUARD_US   = GUARD_US_DEF,
  parameter int TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int POS_W      = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             pulse_err,
  output logic             signal_lost
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam logic [WIDTH_W-1:0] LO_LIM    = WIDTH_W'(MIN_US - GUARD_US);
  localparam logic [WIDTH_W-1:0] HI_LIM    = WIDTH_W'(MAX_US + GUARD_US);
  localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_US);
  localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_US);
  localparam logic [SINCE_W-1:0] TIMEOUT_C = SINCE_W'(TIMEOUT_US);
  localparam logic [POS_W-1:0]   CENTER    = POS_W'((MAX_US - MIN_US) / 2);

  // Synchronizer and edge history are deliberately not reset: after a reset that
  // lands mid-pulse they still hold "high", so no false rise is seen on release.
  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q, fall_q;
  logic       tick;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], pwm_in};
    prev_q <= sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sync_q[1] & ~prev_q;
      fall_q <= prev_q & ~sync_q[1];
    end
  end

  us_tick_gen #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (rise_q),
    .tick(tick)
  );

  dec_state_t         state_q, state_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [SINCE_W-1:0] since_q, since_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               pos_valid_q, pos_valid_d;
  logic               pulse_err_q, pulse_err_d;
  logic               lost_q, lost_d;
  logic               timeout_hit;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    since_d     = since_q;
    pos_d       = pos_q;
    pos_valid_d = 1'b0;
    pulse_err_d = 1'b0;
    lost_d      = lost_q;

    if (rise_q) since_d = '0;
    else if (tick && since_q != TIMEOUT_C) since_d = since_q + 1'b1;
    timeout_hit = (since_d == TIMEOUT_C) && (since_q != TIMEOUT_C);

    case (state_q)
      WAIT_LOW: if (!sync_q[1]) state_d = ARMED;
      ARMED: begin
        if (rise_q) begin
          state_d = MEASURE;
          width_d = '0;
        end
      end
      MEASURE: begin
        if (tick && width_q != '1) width_d = width_q + 1'b1;
        // width_d includes the tick landing on the fall cycle
        if (fall_q) begin
          state_d = ARMED;
          if (width_d < LO_LIM || width_d > HI_LIM) begin
            pulse_err_d = 1'b1;
          end else begin
            pos_valid_d = 1'b1;
            pos_d       = POS_W'(clamp_w(width_d, MIN_W, MAX_W) - MIN_W);
          end
        end else if (timeout_hit) begin
          state_d = WAIT_LOW;
        end
      end
      default: state_d = WAIT_LOW;
    endcase

    if (timeout_hit) lost_d = 1'b1;
    if (pos_valid_d) lost_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOW;
      width_q     <= '0;
      since_q     <= '0;
      pos_q       <= CENTER;
      pos_valid_q <= 1'b0;
      pulse_err_q <= 1'b0;
      lost_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      since_q     <= since_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      pulse_err_q <= pulse_err_d;
      lost_q      <= lost_d;
    end
  end

  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign pulse_err   = pulse_err_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with time scaled down 10x (2 clk per us)
// so the timeout scenarios stay short.
module tb_servo_pwm_decoder;

  localparam int CLK_HZ     = 2_000_000;
  localparam int DIV        = 2;
  localparam int MIN_US     = 100;
  localparam int MAX_US     = 200;
  localparam int GUARD_US   = 10;
  localparam int TIMEOUT_US = 2500;
  localparam int POS_W      = 10;
  localparam int CENTER     = 50;
  localparam int TO_EARLY   = 4 + (TIMEOUT_US - 1) * DIV;
  localparam int TO_LATE    = 4 + (TIMEOUT_US + 1) * DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic [POS_W-1:0] pos;
  logic             pos_valid;
  logic             pulse_err;
  logic             signal_lost;

  servo_pwm_decoder #(
    .CLK_HZ    (CLK_HZ),
    .MIN_US    (MIN_US),
    .MAX_US    (MAX_US),
    .GUARD_US  (GUARD_US),
    .TIMEOUT_US(TIMEOUT_US),
    .POS_W     (POS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .pulse_err  (pulse_err),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic is_err;
    int   pos;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe pops the oldest expectation
  always @(negedge clk) begin
    if (!rst && (pos_valid || pulse_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'({pos_valid, pulse_err}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", 32'({pos_valid, pulse_err}), e.is_err ? 32'd1 : 32'd2);
        check("strobe_pos", 32'(pos), 32'(e.pos));
        if (!e.is_err) check("lost_cleared_with_valid", 32'(signal_lost), 32'd0);
        $display("txn %s pos=%0d expected_pos=%0d lost=%0d",
                 pulse_err ? "err" : "valid", pos, e.pos, signal_lost);
      end
    end
  end

  task automatic wait_us(input int us);
    repeat (us * DIV) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int w_us, input int gap_us, input logic strobe,
                       input logic is_err, input int exp_pos);
    exp_t e;
    e.is_err = is_err;
    e.pos    = exp_pos;
    if (strobe) sb.push_back(e);
    pwm_in = 1'b1;
    wait_us(w_us);
    pwm_in = 1'b0;
    wait_us(gap_us);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pos"}, 32'(pos), 32'(CENTER));
    check({tag, "_pos_valid"}, 32'(pos_valid), 32'd0);
    check({tag, "_pulse_err"}, 32'(pulse_err), 32'd0);
    check({tag, "_signal_lost"}, 32'(signal_lost), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_us(2);

    // Centre pulse clears signal_lost
    pulse(150, 30, 1'b1, 1'b0, 50);
    check("t1_lost", 32'(signal_lost), 32'd0);

    // Nominal, clamped and guard-edge widths
    pulse(100, 30, 1'b1, 1'b0, 0);
    pulse(200, 30, 1'b1, 1'b0, 100);
    pulse(95, 30, 1'b1, 1'b0, 0);
    pulse(208, 30, 1'b1, 1'b0, 100);
    pulse(90, 30, 1'b1, 1'b0, 0);
    pulse(210, 30, 1'b1, 1'b0, 100);
    pulse(89, 30, 1'b1, 1'b1, 100);
    pulse(211, 30, 1'b1, 1'b1, 100);
    check("t2_pos_after_err", 32'(pos), 32'd100);

    // Short pulse after a valid one: error only, pos held, lost untouched
    pulse(150, 30, 1'b1, 1'b0, 50);
    pulse(85, 30, 1'b1, 1'b1, 50);
    check("t3_pos_held", 32'(pos), 32'd50);
    check("t3_lost", 32'(signal_lost), 32'd0);

    // Valid pulse then silence: lost within +-1 us of TIMEOUT after the rise
    sb.push_back('{1'b0, 60});
    pwm_in = 1'b1;
    wait_us(160);
    pwm_in = 1'b0;
    repeat (TO_EARLY - 160 * DIV) @(posedge clk);
    #1;
    check("t4_lost_early", 32'(signal_lost), 32'd0);
    repeat (TO_LATE - TO_EARLY) @(posedge clk);
    #1;
    check("t4_lost_late", 32'(signal_lost), 32'd1);
    pulse(120, 30, 1'b1, 1'b0, 20);
    check("t4_recovered_lost", 32'(signal_lost), 32'd0);
    check("t4_recovered_pos", 32'(pos), 32'd20);

    // Stuck high: lost at timeout, no strobe on the eventual fall
    pwm_in = 1'b1;
    repeat (TO_EARLY) @(posedge clk);
    #1;
    check("t5_lost_early", 32'(signal_lost), 32'd0);
    repeat (TO_LATE - TO_EARLY) @(posedge clk);
    #1;
    check("t5_lost_late", 32'(signal_lost), 32'd1);
    repeat (3000 * DIV - TO_LATE) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    wait_us(100);
    check("t5_lost_held", 32'(signal_lost), 32'd1);
    check("t5_pos_held", 32'(pos), 32'd20);
    pulse(170, 30, 1'b1, 1'b0, 70);
    check("t5_pos", 32'(pos), 32'd70);

    // Reset mid-pulse aborts it; the remainder must not be measured
    pwm_in = 1'b1;
    wait_us(30);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    wait_us(120);
    pwm_in = 1'b0;
    wait_us(50);
    check("t6_pos_after_partial", 32'(pos), 32'(CENTER));
    check("t6_no_pending", 32'(sb.size()), 32'd0);

    // Full pulse after reset with 4-cycle latency from the falling edge
    sb.push_back('{1'b0, 10});
    pwm_in = 1'b1;
    wait_us(110);
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_latency_early", 32'(pos_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t6_latency_valid", 32'(pos_valid), 32'd1);
    check("t6_latency_pos", 32'(pos), 32'd10);
    wait_us(20);
    check("t6_lost", 32'(signal_lost), 32'd0);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
